// File: rtl/virq_pkg.sv
// Shared types, well-known vectors and the rotating priority pick for the vectored-interrupt arbiter.
package virq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        NOVEC = 2'd3
    } virq_state_e;

    localparam logic [7:0] VEC_KBD     = 8'o060;
    localparam logic [7:0] VEC_KBD_AR2 = 8'o274;
    localparam logic [7:0] VEC_TIMER   = 8'o100;

    // First set bit of req[n-1:0] searching upward from start, wrapping; 0 when none is set.
    function automatic int unsigned prio_pick(input logic [31:0] req,
                                              input int unsigned start,
                                              input int unsigned n);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = 32'd0;
        found = 1'b0;
        for (int unsigned k = 0; k < 32; k++) begin
            idx = start + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k < n) && !found && req[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/virq_prio_enc.sv
// Combinational priority encoder with a rotating start index, shared by fixed and round-robin modes.
module virq_prio_enc
    import virq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Pick the first requester at or above start, with wrap-around.
    always_comb begin
        idx   = IW'(prio_pick(32'(req), 32'(start), NREQ));
        valid = |req;
    end

endmodule

// File: rtl/virq_arbiter.sv
// Shares the CPU vectored-interrupt channel among NREQ requesters; advances only on ce_cpu_p.
// Optional macro VIRQ_ROUND_ROBIN_EN replaces fixed priority with a rotating start pointer.
module virq_arbiter
    import virq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int VW   = 8
) (
    input  logic              clk_sys,
    input  logic              bus_reset_n,
    input  logic              ce_cpu_p,
    input  logic [NREQ-1:0]   virq_req,
    input  logic [NREQ*VW-1:0] virq_vec,
    output logic [NREQ-1:0]   virq_ack,
    input  logic              irq_en,
    output logic              cpu_irq,
    input  logic              iak_stb,
    output logic [VW-1:0]     iak_vec,
    output logic              iak_ack
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    virq_state_e       state_r, state_nxt_s;
    logic [IW-1:0]     win_r, win_nxt_s;
    logic [VW-1:0]     vec_r, vec_nxt_s;
    logic              iak_ack_r, iak_ack_nxt_s;
    logic [NREQ-1:0]   virq_ack_r, virq_ack_nxt_s;
    logic              cpu_irq_r, cpu_irq_nxt_s;
    logic              stb_prev_r, stb_prev_nxt_s;
    logic [IW-1:0]     start_s, enc_idx_s;
    logic              enc_valid_s, stb_rise_s, take_grant_s;
    logic [VW-1:0]     sel_vec_s;
    logic [NREQ-1:0]   ack_onehot_s;

    virq_prio_enc #(.NREQ(NREQ), .IW(IW)) u_prio_enc (
        .req   (virq_req),
        .start (start_s),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    assign stb_rise_s   = ce_cpu_p && iak_stb && !stb_prev_r && (state_r == IDLE);
    assign take_grant_s = stb_rise_s && enc_valid_s;
    assign ack_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_r;

`ifdef VIRQ_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_r, ptr_nxt_s;

    // Pointer moves past the winner each time a grant is taken.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (take_grant_s) begin
            ptr_nxt_s = (enc_idx_s == IW'(NREQ - 1)) ? {IW{1'b0}} : enc_idx_s + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_sys) begin
        if (!bus_reset_n) begin
            ptr_r <= {IW{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign start_s = ptr_r;
`else
    assign start_s = {IW{1'b0}};
`endif

    // Vector of the encoder's current pick.
    always_comb begin
        sel_vec_s = {VW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (enc_idx_s == IW'(i)) begin
                sel_vec_s = virq_vec[i*VW +: VW];
            end else begin
                sel_vec_s = sel_vec_s;
            end
        end
    end

    // Next-state and next-output logic; nothing moves without ce_cpu_p.
    always_comb begin
        state_nxt_s    = state_r;
        win_nxt_s      = win_r;
        vec_nxt_s      = vec_r;
        iak_ack_nxt_s  = iak_ack_r;
        virq_ack_nxt_s = virq_ack_r;
        cpu_irq_nxt_s  = cpu_irq_r;
        stb_prev_nxt_s = stb_prev_r;
        if (ce_cpu_p) begin
            cpu_irq_nxt_s  = (state_r == IDLE) && |(virq_req & {NREQ{irq_en}});
            stb_prev_nxt_s = iak_stb;
            case (state_r)
                IDLE: begin
                    if (take_grant_s) begin
                        win_nxt_s   = enc_idx_s;
                        vec_nxt_s   = sel_vec_s;
                        state_nxt_s = GRANT;
                    end else if (stb_rise_s) begin
                        state_nxt_s = NOVEC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                GRANT: begin
                    iak_ack_nxt_s  = 1'b1;
                    virq_ack_nxt_s = ack_onehot_s;
                    state_nxt_s    = HOLD;
                end
                HOLD: begin
                    if (!iak_stb) begin
                        iak_ack_nxt_s  = 1'b0;
                        virq_ack_nxt_s = {NREQ{1'b0}};
                        vec_nxt_s      = {VW{1'b0}};
                        state_nxt_s    = IDLE;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                NOVEC: begin
                    if (!iak_stb) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = NOVEC;
                    end
                end
                default: begin
                    iak_ack_nxt_s  = 1'b0;
                    virq_ack_nxt_s = {NREQ{1'b0}};
                    vec_nxt_s      = {VW{1'b0}};
                    state_nxt_s    = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and registered outputs; reset wins over ce_cpu_p.
    always_ff @(posedge clk_sys) begin
        if (!bus_reset_n) begin
            state_r    <= IDLE;
            win_r      <= {IW{1'b0}};
            vec_r      <= {VW{1'b0}};
            iak_ack_r  <= 1'b0;
            virq_ack_r <= {NREQ{1'b0}};
            cpu_irq_r  <= 1'b0;
            stb_prev_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            win_r      <= win_nxt_s;
            vec_r      <= vec_nxt_s;
            iak_ack_r  <= iak_ack_nxt_s;
            virq_ack_r <= virq_ack_nxt_s;
            cpu_irq_r  <= cpu_irq_nxt_s;
            stb_prev_r <= stb_prev_nxt_s;
        end
    end

    assign virq_ack = virq_ack_r;
    assign cpu_irq  = cpu_irq_r;
    assign iak_vec  = vec_r;
    assign iak_ack  = iak_ack_r;

endmodule

// File: tb/tb_virq_arbiter.sv
// Randomized bench for virq_arbiter against a transaction-level reference (honours VIRQ_ROUND_ROBIN_EN).
module tb_virq_arbiter;

    logic        clk_sys = 1'b0;
    logic        bus_reset_n = 1'b0;
    logic        ce_cpu_p = 1'b0;
    logic [3:0]  virq_req = 4'd0;
    logic [31:0] virq_vec;
    logic [3:0]  virq_ack;
    logic        irq_en = 1'b0;
    logic        cpu_irq;
    logic        iak_stb = 1'b0;
    logic [7:0]  iak_vec;
    logic        iak_ack;

    logic [7:0]  vec_tab [4];
    int          checks = 0;
    int          errors = 0;
    int          ref_ptr = 0;
    int          won;

    assign virq_vec = {vec_tab[3], vec_tab[2], vec_tab[1], vec_tab[0]};

    virq_arbiter #(.NREQ(4), .VW(8)) dut (
        .clk_sys     (clk_sys),
        .bus_reset_n (bus_reset_n),
        .ce_cpu_p    (ce_cpu_p),
        .virq_req    (virq_req),
        .virq_vec    (virq_vec),
        .virq_ack    (virq_ack),
        .irq_en      (irq_en),
        .cpu_irq     (cpu_irq),
        .iak_stb     (iak_stb),
        .iak_vec     (iak_vec),
        .iak_ack     (iak_ack)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference winner: first request at or after the pointer, wrapping.
    function automatic int ref_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One CPU clock enable, preceded by 0..2 idle system clocks.
    task automatic ce_step();
        repeat ($urandom_range(0, 2)) begin
            ce_cpu_p = 1'b0;
            @(posedge clk_sys); #1;
        end
        ce_cpu_p = 1'b1;
        @(posedge clk_sys); #1;
        ce_cpu_p = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ack"}, iak_ack, 32'd0);
        check_eq({tag, "_vack"}, virq_ack, 32'd0);
        check_eq({tag, "_vec"}, iak_vec, 32'd0);
        check_eq({tag, "_irq"}, cpu_irq, 32'd0);
    endtask

    // Full acknowledge cycle; the winner is frozen at the strobe edge.
    task automatic run_iak(input string tag, input bit clear_req, output int w);
        logic [7:0] exp_vec;
        w = ref_pick(virq_req, ref_ptr);
        iak_stb = 1'b1;
        ce_step();
        check_eq({tag, "_early_ack"}, iak_ack, 32'd0);
        check_eq({tag, "_early_vack"}, virq_ack, 32'd0);
        ce_step();
        if (w < 0) begin
            repeat (4) begin
                check_eq({tag, "_spur_ack"}, iak_ack, 32'd0);
                check_eq({tag, "_spur_vack"}, virq_ack, 32'd0);
                ce_step();
            end
        end else begin
            exp_vec = vec_tab[w];
            check_eq({tag, "_ack"}, iak_ack, 32'd1);
            check_eq({tag, "_vec"}, iak_vec, 32'(exp_vec));
            check_eq({tag, "_vack"}, virq_ack, 32'(4'b0001 << w));
            if (clear_req) virq_req[w] = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                ce_step();
                check_eq({tag, "_hold_ack"}, iak_ack, 32'd1);
                check_eq({tag, "_hold_vec"}, iak_vec, 32'(exp_vec));
                check_eq({tag, "_hold_vack"}, virq_ack, 32'(4'b0001 << w));
                check_eq({tag, "_hold_irq"}, cpu_irq, 32'd0);
            end
`ifdef VIRQ_ROUND_ROBIN_EN
            ref_ptr = (w + 1) % 4;
`endif
        end
        iak_stb = 1'b0;
        ce_step();
        check_idle_outputs({tag, "_end"});
    endtask

    initial begin
        vec_tab[0] = 8'o060;
        vec_tab[1] = 8'o274;
        vec_tab[2] = 8'o100;
        vec_tab[3] = 8'o300;

        // Reset with ce low must still clear everything.
        repeat (3) @(posedge clk_sys);
        #1;
        check_idle_outputs("reset");
        bus_reset_n = 1'b1;
        ce_step();

        // Single request on index 1.
        virq_req = 4'b0010;
        irq_en   = 1'b1;
        check_eq("single_irq_before", cpu_irq, 32'd0);
        ce_step();
        check_eq("single_irq", cpu_irq, 32'd1);
        run_iak("single", 1'b1, won);

        // Two simultaneous requests served one after another.
        virq_req = 4'b0101;
        run_iak("dual_a", 1'b1, won);
        run_iak("dual_b", 1'b1, won);

        // irq_en gates cpu_irq.
        irq_en   = 1'b0;
        virq_req = 4'b1000;
        repeat (3) begin
            ce_step();
            check_eq("masked_irq", cpu_irq, 32'd0);
        end
        irq_en = 1'b1;
        ce_step();
        check_eq("unmasked_irq", cpu_irq, 32'd1);
        run_iak("masked", 1'b1, won);

        // Spurious acknowledge: no iak_ack for 50 ce, then normal service.
        virq_req = 4'b0000;
        iak_stb  = 1'b1;
        repeat (50) begin
            ce_step();
            check_eq("spur_ack", iak_ack, 32'd0);
        end
        iak_stb = 1'b0;
        ce_step();
        check_idle_outputs("spur_end");
        virq_req = 4'b0100;
        run_iak("after_spur", 1'b1, won);

        // Winner drops and a higher-priority request arrives mid-HOLD, then reset in HOLD.
        virq_req = 4'b0010;
        iak_stb  = 1'b1;
        ce_step();
        ce_step();
        virq_req = 4'b0001;
        repeat (2) begin
            ce_step();
            check_eq("frozen_vec", iak_vec, 32'(8'o274));
            check_eq("frozen_vack", virq_ack, 32'(4'b0010));
            check_eq("frozen_ack", iak_ack, 32'd1);
        end
        bus_reset_n = 1'b0;
        @(posedge clk_sys); #1;
        check_eq("hold_rst_ack", iak_ack, 32'd0);
        check_eq("hold_rst_vack", virq_ack, 32'd0);
        check_eq("hold_rst_vec", iak_vec, 32'd0);
        check_eq("hold_rst_irq", cpu_irq, 32'd0);
        ref_ptr     = 0;
        virq_req    = 4'b0000;
        iak_stb     = 1'b0;
        bus_reset_n = 1'b1;
        ce_step();

        // All requests held: grant order depends on the arbitration mode.
        virq_req = 4'b1111;
        repeat (5) run_iak("all_held", 1'b0, won);
        virq_req = 4'b0000;
        ce_step();

        // Random traffic, vectors and masking.
        repeat (25) begin
            for (int i = 0; i < 4; i++) vec_tab[i] = 8'($urandom_range(0, 255));
            virq_req = 4'($urandom_range(0, 15));
            irq_en   = 1'($urandom_range(0, 1));
            ce_step();
            check_eq("rand_irq", cpu_irq, 32'(|(virq_req & {4{irq_en}})));
            run_iak("rand", 1'($urandom_range(0, 1)), won);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/virq_arbiter.md
Name: virq_arbiter

Overview:
- Shares the CPU's single vectored-interrupt channel among NREQ requesters, e.g. keyboard vector 060, keyboard vector 0274, timer and serial.
- Sits between the peripherals' virq_req/virq_ack pairs and the CPU core's interrupt request and vector-acknowledge handshake.
- Chooses the winning request, presents its vector, and returns an acknowledge to the winner only.
- Runs on clk_sys and advances only on ce_cpu_p.

Parameters:
- NREQ, 4, number of requesters; index 0 has the highest priority.
- VW, 8, vector width in bits.

Ports:
- clk_sys  in  1  system clock
- bus_reset_n  in  1  synchronous reset, active-low
- ce_cpu_p  in  1  CPU clock enable; all state advances only when it is high
- virq_req  in  NREQ  level request per requester, held until that requester sees its ack
- virq_vec  in  NREQ*VW  vector per requester; slice i is bits [i*VW +: VW]
- virq_ack  out  NREQ  acknowledge to the granted requester; requesters clear on its rising edge
- irq_en  in  1  CPU priority allows interrupts
- cpu_irq  out  1  interrupt request to the CPU
- iak_stb  in  1  CPU vector-read strobe (interrupt acknowledge cycle)
- iak_vec  out  VW  vector driven during the acknowledge cycle
- iak_ack  out  1  vector valid / acknowledge cycle complete

Behaviour:
- Reset (bus_reset_n low at a clk_sys edge, regardless of ce_cpu_p):
  - state IDLE; all outputs 0; grant index 0.
  - Round-robin pointer (when compiled in) set to 0.
- pending = virq_req AND irq_en.
- cpu_irq = (state == IDLE) AND |pending, registered on ce_cpu_p, so it appears one ce after the request.
- State IDLE: on a ce where iak_stb is high and the previous sampled iak_stb was low:
  - If |virq_req: latch winner = lowest index with req set, latch its vector into iak_vec, go to GRANT.
  - If no req is set: go to NOVEC.
- State GRANT: next ce, assert iak_ack and virq_ack[winner], go to HOLD.
- State HOLD:
  - iak_ack and virq_ack[winner] stay high while iak_stb is high.
  - When a ce samples iak_stb low: drop both, clear iak_vec to 0, go to IDLE.
- State NOVEC: spurious acknowledge.
  - iak_ack is never asserted; the CPU's bus timeout handles it.
  - Stay in NOVEC until a ce samples iak_stb low, then go to IDLE.
- Latching rules:
  - The winner is frozen at latch time. Later requests, or the winner's req dropping, do not change iak_vec or the ack target.
  - A request that rises on the same ce as the iak_stb edge is included in arbitration.
  - irq_en is ignored once the acknowledge cycle has started.
- Exactly one virq_ack bit may be high at any time (one-hot or zero).
- Reset in GRANT or HOLD: all acks drop on the same clock edge, with no pulse stretching.
- Overall latency: iak_stb rising (first ce sampling it) to iak_ack high is 2 ce.

Optional Feature:
- Macro VIRQ_ROUND_ROBIN_EN.
- Defined:
  - A pointer holds the last granted index plus 1, modulo NREQ.
  - The winner is the first set req searching from the pointer upward with wrap-around.
  - The pointer updates on entry to GRANT.
- Undefined: fixed priority, lowest index wins, and no pointer register exists.

Decomposition:
- Package virq_pkg:
  - state enum: IDLE, GRANT, HOLD, NOVEC.
  - Localparam vectors VEC_KBD = 8'o060, VEC_KBD_AR2 = 8'o274, VEC_TIMER = 8'o100.
  - Function prio_pick(req, start) returning the winning index.
- Sub-module virq_prio_enc: a combinational priority encoder with rotate-start input, used by both the fixed and round-robin modes.

Test Plan:
- Single request, index 1 with vector 0274:
  - req[1] high, irq_en=1 → cpu_irq high after 1 ce.
  - iak_stb high → iak_vec=0274 and iak_ack high 2 ce later, virq_ack=4'b0010.
  - iak_stb low → all outputs 0.
- Simultaneous req[0] (060) and req[2] (100) in fixed mode:
  - First acknowledge → vector 060, ack[0].
  - After req[0] clears, the second acknowledge → vector 100, ack[2].
- With irq_en=0 and req[3] high: cpu_irq stays 0. Setting irq_en=1 raises cpu_irq on the next ce.
- Spurious cycle: iak_stb high with no req → iak_ack stays 0 for 50 ce. On iak_stb low, the block returns to IDLE and the next request is served normally.
- Winner req[1] dropped mid-HOLD and req[0] raised: iak_vec stays on vector 1, ack stays on bit 1. Reset asserted in HOLD clears all outputs on the next clock edge.
- With VIRQ_ROUND_ROBIN_EN and req=4'b1111 held: successive grants go 0, 1, 2, 3, 0, wrapping around.
